// File: rtl/uart_word_pkg.sv
// Shared types and elaboration-time helpers for the UART receive-side word joiner.
package uart_word_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // One UART character on the line: start bit, 8 data bits, stop bit.
  localparam int BITS_PER_CHAR = 10;

  function automatic int num_parts(input int word_size, input int word_part);
    return word_size / word_part;
  endfunction

  function automatic int timeout_cycles(input int clq_freq, input int baud_rate,
                                        input int timeout_chars);
    return timeout_chars * BITS_PER_CHAR * (clq_freq / baud_rate);
  endfunction

endpackage

// File: rtl/word_fifo.sv
// First-word-fall-through synchronous FIFO; a push while full is accepted when a pop
// happens on the same edge.
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic             w_enable,
  input  logic             r_enable,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = r_enable && !empty;
  assign w_push = w_enable && (!full || w_pop);

  // NOTE: the storage array has no reset; only pointers and the count are cleared,
  // and data_out is masked while empty so nothing stale is ever visible.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign full     = (r_count == (AW+1)'(DEPTH));
  assign empty    = (r_count == '0);
  assign data_out = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/uart_word_join.sv
// Reassembles UART characters into words (least-significant part first), discards
// stale partial words after an idle timeout, and queues complete words in a FWFT FIFO.
module uart_word_join
  import uart_word_pkg::*;
#(
  parameter int WORD_SIZE     = 32,
  parameter int WORD_PART     = 8,
  parameter int MEM_SIZE      = 64,
  parameter int CLQ_FREQ      = 200_000_000,
  parameter int BAUD_RATE     = 115200,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic                                                 clock,
  input  logic                                                 rstn,
  input  logic [WORD_PART-1:0]                                 part_in,
  input  logic                                                 part_valid,
  output logic [WORD_SIZE-1:0]                                 word_out,
  output logic                                                 valid_o,
  input  logic                                                 ready_i,
  output logic                                                 full,
  output logic                                                 empty,
  output logic                                                 overflow,
  output logic                                                 timeout_drop,
  output logic [$clog2(num_parts(WORD_SIZE, WORD_PART)):0]     part_cnt
);

  localparam int NUM_PARTS   = num_parts(WORD_SIZE, WORD_PART);
  localparam int TIMEOUT_CYC = timeout_cycles(CLQ_FREQ, BAUD_RATE, TIMEOUT_CHARS);
  localparam int CNT_W       = $clog2(NUM_PARTS) + 1;
  localparam int TMO_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST =
    (TIMEOUT_CYC > 0) ? TMO_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PARTS - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_part_cnt;
  logic [CNT_W-1:0]     w_part_cnt_next;
  logic [WORD_SIZE-1:0] r_asm;
  logic [WORD_SIZE-1:0] w_asm_next;
  logic [TMO_W-1:0]     r_tmo;
  logic [TMO_W-1:0]     w_tmo_next;
  logic [WORD_SIZE-1:0] w_word;
  logic                 w_complete;
  logic                 w_expire;
  logic                 w_pop;
  logic                 r_overflow;
  logic                 r_timeout_drop;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_state        <= IDLE;
      r_part_cnt     <= '0;
      r_asm          <= '0;
      r_tmo          <= '0;
      r_overflow     <= 1'b0;
      r_timeout_drop <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_part_cnt     <= w_part_cnt_next;
      r_asm          <= w_asm_next;
      r_tmo          <= w_tmo_next;
      r_overflow     <= w_complete && w_fifo_full && !w_pop;
      r_timeout_drop <= w_expire;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next    = r_state;
    w_part_cnt_next = r_part_cnt;
    w_asm_next      = r_asm;
    w_tmo_next      = r_tmo;
    w_complete      = 1'b0;
    w_expire        = 1'b0;
    w_word          = r_asm;
    w_word[int'(r_part_cnt)*WORD_PART +: WORD_PART] = part_in;

    if (part_valid) begin
      // A part always wins over a coincident timeout expiry.
      w_tmo_next = '0;
      if (r_part_cnt == CNT_LAST) begin
        w_complete      = 1'b1;
        w_part_cnt_next = '0;
        w_asm_next      = '0;
        w_state_next    = IDLE;
      end else begin
        w_part_cnt_next = r_part_cnt + CNT_W'(1);
        w_asm_next      = w_word;
        w_state_next    = COLLECT;
      end
    end else if (r_state == COLLECT && TIMEOUT_CYC > 0) begin
      if (r_tmo == TMO_LAST) begin
        w_expire        = 1'b1;
        w_part_cnt_next = '0;
        w_asm_next      = '0;
        w_tmo_next      = '0;
        w_state_next    = IDLE;
      end else begin
        w_tmo_next = r_tmo + TMO_W'(1);
      end
    end
  end

  assign w_pop = !w_fifo_empty && ready_i;

  word_fifo #(
    .WIDTH (WORD_SIZE),
    .DEPTH (MEM_SIZE)
  ) u_fifo (
    .clock    (clock),
    .rstn     (rstn),
    .w_enable (w_complete),
    .r_enable (ready_i),
    .data_in  (w_word),
    .data_out (word_out),
    .full     (w_fifo_full),
    .empty    (w_fifo_empty)
  );

  assign valid_o      = !w_fifo_empty;
  assign full         = w_fifo_full;
  assign empty        = w_fifo_empty;
  assign overflow     = r_overflow;
  assign timeout_drop = r_timeout_drop;
  assign part_cnt     = r_part_cnt;

endmodule

// File: tb/tb_uart_word_join.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed
// literal checks and a randomized traffic phase.
module tb_uart_word_join;

  localparam int WS  = 32;
  localparam int NP  = 4;
  localparam int MEM = 4;
  localparam int TC  = 100;

  logic        clock = 1'b0;
  logic        rstn  = 1'b0;
  logic [7:0]  part_in = '0;
  logic        part_valid = 1'b0;
  logic        ready_i = 1'b0;
  logic [31:0] word_out;
  logic        valid_o, full, empty, overflow, timeout_drop;
  logic [2:0]  part_cnt;

  logic [7:0]  part_in16 = '0;
  logic        part_valid16 = 1'b0;
  logic        ready16 = 1'b0;
  logic [15:0] word16;
  logic        valid16, full16, empty16, ovf16, tdrop16;
  logic [1:0]  part_cnt16;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  uart_word_join #(
    .WORD_SIZE(WS), .WORD_PART(8), .MEM_SIZE(MEM),
    .CLQ_FREQ(1_152_000), .BAUD_RATE(115200), .TIMEOUT_CHARS(1)
  ) dut (
    .clock(clock), .rstn(rstn), .part_in(part_in), .part_valid(part_valid),
    .word_out(word_out), .valid_o(valid_o), .ready_i(ready_i), .full(full),
    .empty(empty), .overflow(overflow), .timeout_drop(timeout_drop), .part_cnt(part_cnt)
  );

  uart_word_join #(
    .WORD_SIZE(16), .WORD_PART(8), .MEM_SIZE(4),
    .CLQ_FREQ(1_152_000), .BAUD_RATE(115200), .TIMEOUT_CHARS(1)
  ) dut16 (
    .clock(clock), .rstn(rstn), .part_in(part_in16), .part_valid(part_valid16),
    .word_out(word16), .valid_o(valid16), .ready_i(ready16), .full(full16),
    .empty(empty16), .overflow(ovf16), .timeout_drop(tdrop16), .part_cnt(part_cnt16)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: pending parts and stored words as queues, timeout from edge stamps.
  logic [7:0]  m_parts[$];
  logic [31:0] m_fifo[$];
  longint      m_cyc  = 0;
  longint      m_last = 0;
  bit          m_ovf  = 0;
  bit          m_tdrop = 0;
  bit          m_pop, m_done;
  logic [31:0] m_word;

  always @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      m_parts.delete();
      m_fifo.delete();
      m_ovf   = 0;
      m_tdrop = 0;
      m_cyc   = 0;
    end else begin
      m_cyc++;
      m_ovf   = 0;
      m_tdrop = 0;
      m_done  = 0;
      m_word  = '0;
      m_pop   = (m_fifo.size() > 0) && ready_i;
      if (part_valid) begin
        m_parts.push_back(part_in);
        m_last = m_cyc;
        if (m_parts.size() == NP) begin
          for (int k = 0; k < NP; k++) m_word = m_word | (32'(m_parts[k]) << (8 * k));
          m_parts.delete();
          m_done = 1;
        end
      end else if (m_parts.size() > 0 && (m_cyc - m_last) == TC) begin
        m_parts.delete();
        m_tdrop = 1;
      end
      if (m_pop) void'(m_fifo.pop_front());
      if (m_done) begin
        if (m_fifo.size() < MEM) m_fifo.push_back(m_word);
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clock) begin
    check("cmp_valid_o", {31'b0, valid_o}, {31'b0, m_fifo.size() > 0});
    check("cmp_word_out", word_out, (m_fifo.size() > 0) ? m_fifo[0] : 32'h0);
    check("cmp_full", {31'b0, full}, {31'b0, m_fifo.size() == MEM});
    check("cmp_empty", {31'b0, empty}, {31'b0, m_fifo.size() == 0});
    check("cmp_overflow", {31'b0, overflow}, {31'b0, m_ovf});
    check("cmp_timeout_drop", {31'b0, timeout_drop}, {31'b0, m_tdrop});
    check("cmp_part_cnt", {29'b0, part_cnt}, 32'(m_parts.size()));
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_part(input logic [7:0] b);
    part_in    = b;
    part_valid = 1'b1;
    tick();
    part_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < NP; k++) begin
      send_part(w[8*k +: 8]);
      if (k < NP - 1) idle(gap);
    end
  endtask

  logic [31:0] ov_w [6] = '{32'h11223344, 32'h55667788, 32'h99AABBCC,
                            32'hDDEEFF00, 32'h0BADF00D, 32'hCAFEBABE};

  initial begin
    idle(3);
    check("reset_empty", {31'b0, empty}, 32'h1);
    check("reset_valid", {31'b0, valid_o}, 32'h0);
    check("reset_full", {31'b0, full}, 32'h0);
    check("reset_word", word_out, 32'h0);
    check("reset_part_cnt", {29'b0, part_cnt}, 32'h0);
    rstn = 1'b1;
    idle(2);

    // Basic assembly with widely spaced strobes.
    ready_i = 1'b1;
    send_word(32'h44332211, 60);
    check("basic_valid", {31'b0, valid_o}, 32'h1);
    check("basic_word", word_out, 32'h44332211);
    tick();
    check("basic_empty", {31'b0, empty}, 32'h1);

    // Backpressure and ordering.
    ready_i = 1'b0;
    send_word(32'hA0A1A2A3, 2);
    send_word(32'hB0B1B2B3, 2);
    send_word(32'hC0C1C2C3, 2);
    idle(3);
    check("bp_full", {31'b0, full}, 32'h0);
    ready_i = 1'b1;
    check("bp_word0", word_out, 32'hA0A1A2A3);
    tick();
    check("bp_word1", word_out, 32'hB0B1B2B3);
    tick();
    check("bp_word2", word_out, 32'hC0C1C2C3);
    tick();
    check("bp_drained", {31'b0, valid_o}, 32'h0);
    ready_i = 1'b0;

    // Overflow, then push-while-full rescued by a same-cycle pop.
    for (int i = 0; i < 4; i++) send_word(ov_w[i], 1);
    check("ov_full", {31'b0, full}, 32'h1);
    send_word(ov_w[4], 1);
    check("ov_pulse", {31'b0, overflow}, 32'h1);
    tick();
    check("ov_pulse_end", {31'b0, overflow}, 32'h0);
    check("ov_head", word_out, ov_w[0]);
    for (int k = 0; k < NP - 1; k++) send_part(ov_w[5][8*k +: 8]);
    ready_i = 1'b1;
    send_part(ov_w[5][31:24]);
    ready_i = 1'b0;
    check("ovp_full", {31'b0, full}, 32'h1);
    check("ovp_no_pulse", {31'b0, overflow}, 32'h0);
    ready_i = 1'b1;
    check("ovp_word1", word_out, ov_w[1]);
    tick();
    check("ovp_word2", word_out, ov_w[2]);
    tick();
    check("ovp_word3", word_out, ov_w[3]);
    tick();
    check("ovp_word5", word_out, ov_w[5]);
    tick();
    check("ovp_drained", {31'b0, empty}, 32'h1);

    // Timeout drop, recovery, and a part landing exactly on the expiry cycle.
    send_part(8'h55);
    send_part(8'h66);
    idle(TC - 1);
    check("to_before", {31'b0, timeout_drop}, 32'h0);
    check("to_cnt_before", {29'b0, part_cnt}, 32'h2);
    tick();
    check("to_pulse", {31'b0, timeout_drop}, 32'h1);
    check("to_cnt_zero", {29'b0, part_cnt}, 32'h0);
    send_word(32'h04030201, 0);
    check("to_recover", word_out, 32'h04030201);
    idle(2);
    send_part(8'h0A);
    send_part(8'h0B);
    idle(TC - 1);
    send_part(8'h0C);
    check("to_edge_nodrop", {31'b0, timeout_drop}, 32'h0);
    check("to_edge_cnt", {29'b0, part_cnt}, 32'h3);
    send_part(8'h0D);
    check("to_edge_word", word_out, 32'h0D0C0B0A);
    idle(2);

    // Reset mid-operation.
    ready_i = 1'b0;
    send_word(32'h01234567, 1);
    send_word(32'h89ABCDEF, 1);
    send_part(8'h77);
    send_part(8'h88);
    rstn = 1'b0;
    idle(3);
    check("rst_empty", {31'b0, empty}, 32'h1);
    check("rst_part_cnt", {29'b0, part_cnt}, 32'h0);
    check("rst_valid", {31'b0, valid_o}, 32'h0);
    rstn = 1'b1;
    tick();
    send_word(32'hDEADBEEF, 1);
    check("rst_new_word", word_out, 32'hDEADBEEF);
    ready_i = 1'b1;
    tick();

    // 16-bit word instance.
    ready16      = 1'b0;
    part_in16    = 8'hCD;
    part_valid16 = 1'b1;
    tick();
    part_in16    = 8'hAB;
    tick();
    part_valid16 = 1'b0;
    check("w16_valid", {31'b0, valid16}, 32'h1);
    check("w16_word", {16'b0, word16}, 32'h0000ABCD);
    ready16 = 1'b1;
    tick();
    check("w16_empty", {31'b0, empty16}, 32'h1);

    // Randomized traffic, including long idle stretches that cross the timeout.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        idle($urandom_range(TC - 3, TC + 3));
      end else begin
        ready_i    = ($urandom_range(0, 3) != 0);
        part_in    = 8'($urandom);
        part_valid = ($urandom_range(0, 2) == 0);
        tick();
        part_valid = 1'b0;
      end
    end
    ready_i = 1'b1;
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_word_join.md
Name: uart_word_join

Overview:
- Receive-side counterpart of the transmit path (FIFO -> word splitter -> UART TX). Sits directly downstream of uart_rx.
- Consumes WORD_PART-bit characters from uart_rx and reassembles them into WORD_SIZE-bit words, least-significant part first.
- Words are buffered in an internal first-word-fall-through FIFO and handed downstream over a valid/ready handshake.
- An inter-character timeout discards stale partial words so a lost byte cannot misalign every later word.

Parameters:
- WORD_SIZE, 32, width of the assembled word; must be an integer multiple of WORD_PART.
- WORD_PART, 8, width of one UART character.
- MEM_SIZE, 64, FIFO depth in words; power of two, at least 2.
- CLQ_FREQ, 200_000_000, clock frequency in Hz.
- BAUD_RATE, 115200, line rate; used to derive the timeout.
- TIMEOUT_CHARS, 4, idle character-times before a partial word is discarded; 0 disables the timeout.

Ports:
- clock  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- part_in  in  WORD_PART  character from uart_rx.
- part_valid  in  1  one-cycle strobe from uart_rx; part_in is valid while it is high.
- word_out  out  WORD_SIZE  head-of-FIFO word.
- valid_o  out  1  word_out is valid (FIFO not empty).
- ready_i  in  1  downstream accepts word_out.
- full  out  1  FIFO holds MEM_SIZE words.
- empty  out  1  FIFO holds no words.
- overflow  out  1  one-cycle pulse: a completed word was dropped.
- timeout_drop  out  1  one-cycle pulse: a partial word was discarded.
- part_cnt  out  $clog2(NUM_PARTS)+1  number of parts currently held.

Behaviour:
- Definitions: NUM_PARTS = WORD_SIZE/WORD_PART. TIMEOUT_CYC = TIMEOUT_CHARS*10*(CLQ_FREQ/BAUD_RATE). The factor 10 covers start bit, 8 data bits and stop bit.
- Reset (rstn low, asynchronous): state=IDLE, part_cnt=0, assembly register=0, timeout counter=0. FIFO pointers cleared, so empty=1, full=0, valid_o=0. word_out=0, overflow=0, timeout_drop=0.
- Reset mid-word or with words in the FIFO discards everything. There is no recovery of partial data.
- FSM has two states:
  - IDLE: part_cnt==0. A part_valid moves the FSM to COLLECT, except when NUM_PARTS==1, where the word completes immediately.
  - COLLECT: 0 < part_cnt < NUM_PARTS. The FSM returns to IDLE on word completion or on timeout.
- Assembly: the k-th part (k = part_cnt at acceptance) lands in bits [k*WORD_PART +: WORD_PART]. Example: 0x11,0x22,0x33,0x44 -> 0x44332211.
- Completion: on the edge where part_valid is high and part_cnt==NUM_PARTS-1, the completed word, including the current part, is written to the FIFO on that same edge. part_cnt returns to 0.
- Latency: valid_o is high in the cycle after the last part strobe when the FIFO was empty. word_out shows the new word in that same cycle.
- Handshake:
  - A pop occurs on an edge with valid_o && ready_i.
  - word_out and valid_o stay stable until popped.
  - ready_i while empty is ignored.
- Full boundary:
  - If a word completes while full and no pop occurs that cycle, the word is dropped, overflow pulses for 1 cycle, and the FIFO is unchanged.
  - If a pop occurs in the same cycle, the push is accepted, full stays 1, and no overflow pulse is raised.
- Simultaneous push and pop with the FIFO non-full and non-empty: the occupancy count is unchanged.
- Pointers wrap modulo MEM_SIZE. full and empty are derived from an occupancy counter of width $clog2(MEM_SIZE)+1.
- Timeout:
  - The counter runs only in COLLECT and is cleared on every part_valid.
  - When it reaches TIMEOUT_CYC-1 with no part_valid that cycle: partial data is discarded, part_cnt=0, state=IDLE, and timeout_drop pulses for 1 cycle.
  - If part_valid coincides with expiry, the part wins: it is appended, the counter is cleared, and there is no drop.
- The FIFO is never affected by a timeout.

Decomposition:
- Package uart_word_pkg contains:
  - state enum {IDLE, COLLECT};
  - function num_parts(WORD_SIZE, WORD_PART);
  - function timeout_cycles(CLQ_FREQ, BAUD_RATE, TIMEOUT_CHARS).
- One sub-module, word_fifo: FWFT synchronous FIFO with async active-low rstn.
  - Ports: w_enable, r_enable, data_in, data_out, full, empty.
  - Same-cycle push-when-full is allowed when a pop is also occurring.
- uart_word_join holds the FSM, assembly register, part counter and timeout counter.

Test Plan:
- Basic assembly: ready_i=1; strobe 0x11,0x22,0x33,0x44 spaced 1736 cycles apart -> valid_o high 1 cycle after the 4th strobe, word_out=0x44332211, empty returns to 1 after the pop.
- Backpressure and order: ready_i=0; send 3 words 0xA0A1A2A3, 0xB0B1B2B3, 0xC0C1C2C3 (each part stream LSB first) -> FIFO holds 3. Raise ready_i -> words pop in order, 1 per cycle, then valid_o=0.
- Overflow (MEM_SIZE=4): ready_i=0, send 5 words -> full=1 after the 4th. The 5th completes with overflow pulsed exactly 1 cycle; the 4 stored words are intact. Repeat with ready_i pulsed on the 5th completion cycle -> no overflow pulse, full stays 1.
- Timeout (TIMEOUT_CYC shortened to 100): send 0x55,0x66, then idle 100 cycles -> timeout_drop pulses, part_cnt=0. Then send 0x01..0x04 -> word 0x04030201. Also send a part exactly on the expiry cycle -> no drop, part_cnt=3.
- Reset mid-operation: 2 words queued plus 2 parts pending; pulse rstn low 3 cycles -> empty=1, part_cnt=0, valid_o=0. Then 4 new parts -> one correct word.
- Parameter sweep: WORD_SIZE=16, WORD_PART=8, bytes 0xCD,0xAB -> word_out=0xABCD.
